// File: rtl/arith_pkg.sv
// arith_pkg: shared state type, default width and helpers for the arithmetic exercise blocks
package arith_pkg;
  localparam int WIDTH_DEFAULT = 2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int cnt_width(int w);
    return w > 2 ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/full_sub.sv
// full_sub: combinational 1-bit full subtractor x - yb - bin
module full_sub (
  input  logic x,
  input  logic yb,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ yb ^ bin;
  assign bout = (~x & yb) | (~(x ^ yb) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, with start/busy/done handshake
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             borrow
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, sr_q, sr_d, y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, borrow_q, borrow_d, busy_q, done_q;
  logic             bit_d, bit_bout, load, step, last, fin;
  full_sub u_fs (
    .x   (sa_q[0]),
    .yb  (sb_q[0]),
    .bin (br_q),
    .d   (bit_d),
    .bout(bit_bout)
  );
  // DONE behaves like IDLE for accepting a new start, giving back-to-back throughput
  always_comb begin
    step     = state_q == RUN;
    load     = !step && start;
    last     = cnt_q == CW'(WIDTH - 1);
    fin      = step && last;
    state_d  = step ? (last ? DONE : RUN) : (start ? RUN : IDLE);
    sa_d     = load ? a : step ? sa_q >> 1 : sa_q;
    sb_d     = load ? b : step ? sb_q >> 1 : sb_q;
    sr_d     = load ? '0 : step ? {bit_d, sr_q[WIDTH-1:1]} : sr_q;
    br_d     = load ? 1'b0 : step ? bit_bout : br_q;
    cnt_d    = load ? '0 : step ? cnt_q + CW'(1) : cnt_q;
    y_d      = fin ? sr_d : y_q;
    borrow_d = fin ? bit_bout : borrow_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      y_q      <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      borrow_q <= borrow_d;
      busy_q   <= state_d == RUN;
      done_q   <= state_d == DONE;
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign y      = y_q;
  assign borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks plus per-cycle reference model for WIDTH=2 and WIDTH=8
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [1:0]       st = '0;
  logic [1:0][31:0] av = '0, bv = '0;
  logic [1:0]       busy_v, done_v, brw_v;
  logic [1:0][31:0] y_v;
  logic [1:0]       y2;
  logic [7:0]       y8;
  int total = 0, bad = 0;
  int wid[2] = '{2, 8};
  serial_subtractor #(.WIDTH(2)) u2 (
    .clk(clk), .reset(rst), .start(st[0]), .a(av[0][1:0]), .b(bv[0][1:0]),
    .busy(busy_v[0]), .done(done_v[0]), .y(y2), .borrow(brw_v[0])
  );
  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst), .start(st[1]), .a(av[1][7:0]), .b(bv[1][7:0]),
    .busy(busy_v[1]), .done(done_v[1]), .y(y8), .borrow(brw_v[1])
  );
  assign y_v[0] = 32'(y2);
  assign y_v[1] = 32'(y8);

  task automatic chk(string n, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, exp);
    end
  endtask

  // Reference: result known at the accepting edge, appears WIDTH edges later
  int          rem[2];
  logic [31:0] py[2], ey[2];
  logic        pb[2], eb[2], ebusy[2], edone[2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        rem[i] = 0; ey[i] = 0; eb[i] = 0; ebusy[i] = 0; edone[i] = 0;
      end else begin
        logic fin;
        logic [31:0] mask;
        mask = (32'd1 << wid[i]) - 1;
        fin = rem[i] == 1;
        if (rem[i] > 0) rem[i]--;
        else if (st[i]) begin
          rem[i] = wid[i];
          py[i] = (av[i] - bv[i]) & mask;
          pb[i] = (av[i] & mask) < (bv[i] & mask);
        end
        if (fin) begin ey[i] = py[i]; eb[i] = pb[i]; end
        edone[i] = fin;
        ebusy[i] = rem[i] > 0;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("w%0d busy", wid[i]), busy_v[i], ebusy[i]);
      chk($sformatf("w%0d done", wid[i]), done_v[i], edone[i]);
      chk($sformatf("w%0d y", wid[i]), y_v[i], ey[i]);
      chk($sformatf("w%0d borrow", wid[i]), brw_v[i], eb[i]);
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic op(int i, int a, int b, int exp_y, int exp_b, output int busy_cnt);
    int cyc;
    av[i] = 32'(a); bv[i] = 32'(b); st[i] = 1'b1;
    tick(1);
    st[i] = 1'b0;
    cyc = 0; busy_cnt = 0;
    while (!done_v[i] && cyc < 40) begin
      busy_cnt += int'(busy_v[i]);
      tick(1);
      cyc++;
    end
    chk($sformatf("w%0d latency %0d-%0d", wid[i], a, b), cyc, wid[i]);
    chk($sformatf("w%0d lit y %0d-%0d", wid[i], a, b), y_v[i], exp_y);
    chk($sformatf("w%0d lit borrow %0d-%0d", wid[i], a, b), brw_v[i], exp_b);
  endtask

  initial begin
    int bc, dn;
    logic [31:0] ylast;
    tick(3);
    rst = 1'b0;
    chk("reset y", y_v[0], 0);
    chk("reset busy", busy_v[1], 0);
    op(0, 2, 1, 1, 0, bc);
    chk("w2 busy cycles", bc, 2);
    op(0, 0, 1, 3, 1, bc);
    op(0, 1, 1, 0, 0, bc);
    op(1, 200, 55, 145, 0, bc);
    chk("w8 busy cycles", bc, 8);
    op(1, 55, 200, 111, 1, bc);
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        op(0, a, b, (a - b) & 3, int'(a < b), bc);
    tick(2);
    av[1] = 10; bv[1] = 3; st[1] = 1'b1;
    tick(1);
    st[1] = 1'b0;
    tick(2);
    av[1] = 99; bv[1] = 1; st[1] = 1'b1;
    tick(1);
    st[1] = 1'b0; av[1] = 0; bv[1] = 0;
    dn = 0;
    for (int j = 0; j < 15; j++) begin tick(1); dn += int'(done_v[1]); end
    chk("midrun done pulses", dn, 1);
    chk("midrun y", y_v[1], 7);
    av[1] = 5; bv[1] = 9; st[1] = 1'b1;
    tick(1);
    st[1] = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort busy", busy_v[1], 0);
    chk("abort done", done_v[1], 0);
    chk("abort y", y_v[1], 0);
    chk("abort borrow", brw_v[1], 0);
    dn = 0;
    for (int j = 0; j < 12; j++) begin tick(1); dn += int'(done_v[1]); end
    chk("abort no done", dn, 0);
    op(1, 9, 5, 4, 0, bc);
    tick(2);
    st[0] = 1'b1;
    dn = 0;
    ylast = 0;
    for (int j = 0; j < 12; j++) begin
      av[0] = (j % 2 == 0) ? 1 : 3;
      bv[0] = (j % 2 == 0) ? 2 : 1;
      tick(1);
      if (done_v[0]) begin dn++; ylast = y_v[0]; end
    end
    st[0] = 1'b0;
    chk("b2b done count", dn, 4);
    chk("b2b last y", ylast, 2);
    tick(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
